// File: rtl/cipher_host_initiator.sv
// Host-side initiator: hands a local word to a cipher with a request/acknowledge handshake,
// then holds the result for a local sink. Optional wait timeout: define CIPHER_HOST_TIMEOUT_EN.
module cipher_host_initiator #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              input_request,
  output logic [DATA_W-1:0] tx_data,
  input  logic              chip_done,
  input  logic [DATA_W-1:0] chip_result,
  output logic              output_acknowledge,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              err_timeout,
  input  logic              err_clear,
  output logic [7:0]        txn_count
);

  typedef enum logic [2:0] {
    H_IDLE,
    H_REQUEST,
    H_WAIT_DONE,
    H_ACK,
    H_DELIVER
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [7:0]        txn_q, txn_d;
  logic              timeout_now;

`ifdef CIPHER_HOST_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  // Counter sits at zero outside the wait state, so every entry starts a fresh count.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    timeout_now = 1'b0;
    if (state_q != H_WAIT_DONE) begin
      wait_cnt_d = '0;
    end else if (!chip_done) begin
      if (wait_cnt_q == TMO_LAST) begin
        timeout_now = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end else if (timeout_now) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_err_clear;

  assign unused_err_clear = err_clear;
  assign timeout_now      = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    tx_d               = tx_q;
    res_d              = res_q;
    txn_d              = txn_q;
    src_ready          = 1'b0;
    input_request      = 1'b0;
    output_acknowledge = 1'b0;
    res_valid          = 1'b0;
    case (state_q)
      H_IDLE: begin
        // A done left over from a previous exchange must clear before a new word goes out.
        src_ready = !chip_done;
        if (src_valid && !chip_done) begin
          tx_d    = src_data;
          state_d = H_REQUEST;
        end
      end
      H_REQUEST: begin
        input_request = 1'b1;
        state_d       = H_WAIT_DONE;
      end
      H_WAIT_DONE: begin
        if (chip_done) begin
          res_d   = chip_result;
          state_d = H_ACK;
        end else if (timeout_now) begin
          state_d = H_IDLE;
        end
      end
      H_ACK: begin
        output_acknowledge = 1'b1;
        state_d            = H_DELIVER;
      end
      H_DELIVER: begin
        res_valid = 1'b1;
        if (res_ready) begin
          txn_d   = txn_q + 8'd1;
          state_d = H_IDLE;
        end
      end
      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= H_IDLE;
      tx_q    <= '0;
      res_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      res_q   <= res_d;
      txn_q   <= txn_d;
    end
  end

  assign tx_data   = tx_q;
  assign res_data  = res_q;
  assign txn_count = txn_q;

endmodule
